// File: rtl/branch_predictor_if.sv
// Fetch-lookup and resolve-update bus of the branch predictor.
// The master side is the pipeline; the slave side is the predictor.
interface branch_predictor_if;
    logic [31:0] lk_pc;
    logic        lk_taken;
    logic [31:0] lk_target;
    logic        up_valid;
    logic [31:0] up_pc;
    logic        up_is_jump;
    logic        up_taken;
    logic [31:0] up_target;
    logic        up_pred_taken;
    logic [31:0] up_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] miss_cnt;

    modport master (
        output lk_pc, up_valid, up_pc, up_is_jump, up_taken, up_target,
               up_pred_taken, up_pred_target,
        input  lk_taken, lk_target, mispredict, redirect_pc, miss_cnt
    );

    modport slave (
        input  lk_pc, up_valid, up_pc, up_is_jump, up_taken, up_target,
               up_pred_taken, up_pred_target,
        output lk_taken, lk_target, mispredict, redirect_pc, miss_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch predictor: zero-latency lookup, saturating
// direction counters, jump flag, stored targets and a mispredict counter.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic             valid_q [ENTRIES];
    logic             valid_d [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [TAG_W-1:0] tag_d   [ENTRIES];
    logic             jmp_q   [ENTRIES];
    logic             jmp_d   [ENTRIES];
    logic [CNT_W-1:0] cnt_q   [ENTRIES];
    logic [CNT_W-1:0] cnt_d   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    logic [31:0]      tgt_d   [ENTRIES];
    logic [31:0]      miss_cnt_q;
    logic [31:0]      miss_cnt_d;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             mispredict;

    assign lk_idx = bp.lk_pc[IDX_W+1:2];
    assign lk_tag = bp.lk_pc[IDX_W+1+TAG_W:IDX_W+2];
    assign up_idx = bp.up_pc[IDX_W+1:2];
    assign up_tag = bp.up_pc[IDX_W+1+TAG_W:IDX_W+2];

    // Lookup reads the registered table, so a same-cycle update is not seen.
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && (jmp_q[lk_idx] || cnt_q[lk_idx][CNT_W-1]);
    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign mispredict = bp.up_valid &&
                        ((bp.up_taken != bp.up_pred_taken) ||
                         (bp.up_taken && (bp.up_target != bp.up_pred_target)));

    assign bp.lk_taken    = lk_taken;
    assign bp.lk_target   = lk_taken ? tgt_q[lk_idx] : bp.lk_pc + 32'd4;
    assign bp.mispredict  = mispredict;
    // Not-taken fall-through skips the delay slot.
    assign bp.redirect_pc = bp.up_taken ? bp.up_target : bp.up_pc + 32'd8;
    assign bp.miss_cnt    = miss_cnt_q;

    always_comb begin
        valid_d    = valid_q;
        tag_d      = tag_q;
        jmp_d      = jmp_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        miss_cnt_d = miss_cnt_q + (mispredict ? 32'd1 : 32'd0);

        if (bp.up_valid) begin
            if (up_hit) begin
                jmp_d[up_idx] = bp.up_is_jump;
                if (bp.up_taken) begin
                    tgt_d[up_idx] = bp.up_target;
                    if (cnt_q[up_idx] != CNT_MAX)
                        cnt_d[up_idx] = cnt_q[up_idx] + CNT_W'(1);
                end else if (cnt_q[up_idx] != '0) begin
                    cnt_d[up_idx] = cnt_q[up_idx] - CNT_W'(1);
                end
            end else if (bp.up_taken) begin
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = bp.up_target;
                jmp_d[up_idx]   = bp.up_is_jump;
                cnt_d[up_idx]   = CNT_WEAK_T;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                jmp_q[i]   <= 1'b0;
                cnt_q[i]   <= CNT_WEAK_NT;
                tgt_q[i]   <= '0;
            end
            miss_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            jmp_q      <= jmp_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations
// (ENTRIES=64: index = pc[7:2], tag = pc[15:8]).
module tb_branch_predictor;
    logic clk;
    logic reset;
    int   checks_cnt;
    int   errors_cnt;

    branch_predictor_if bp_bus ();

    branch_predictor #(.ENTRIES(64), .CNT_W(2), .TAG_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp_bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        bp_bus.lk_pc = pc;
        #1;
    endtask

    task automatic idle_up();
        bp_bus.up_valid       = 1'b0;
        bp_bus.up_pc          = '0;
        bp_bus.up_is_jump     = 1'b0;
        bp_bus.up_taken       = 1'b0;
        bp_bus.up_target      = '0;
        bp_bus.up_pred_taken  = 1'b0;
        bp_bus.up_pred_target = '0;
    endtask

    task automatic drive_up(input logic [31:0] pc, input logic jump, input logic taken,
                            input logic [31:0] target, input logic pred_taken,
                            input logic [31:0] pred_target);
        bp_bus.up_valid       = 1'b1;
        bp_bus.up_pc          = pc;
        bp_bus.up_is_jump     = jump;
        bp_bus.up_taken       = taken;
        bp_bus.up_target      = target;
        bp_bus.up_pred_taken  = pred_taken;
        bp_bus.up_pred_target = pred_target;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        reset = 1'b1;
        bp_bus.lk_pc = 32'h0000_3000;
        idle_up();
        #2 reset = 1'b0;
        tick();
        tick();

        // Behaviour while reset is held
        look(32'h0000_3000);
        check("rst_lk_taken", {31'd0, bp_bus.lk_taken}, 32'd0);
        check("rst_lk_target", bp_bus.lk_target, 32'h0000_3004);
        check("rst_miss_cnt", bp_bus.miss_cnt, 32'd0);
        drive_up(32'h3010, 1'b0, 1'b1, 32'h3040, 1'b0, 32'h3014);
        settle();
        check("rst_mispredict", {31'd0, bp_bus.mispredict}, 32'd1);
        tick();
        check("rst_miss_hold", bp_bus.miss_cnt, 32'd0);
        idle_up();
        look(32'h0000_3010);
        check("rst_no_alloc", {31'd0, bp_bus.lk_taken}, 32'd0);
        reset = 1'b1;
        tick();

        // Post-reset lookup
        look(32'h0000_3000);
        check("init_lk_taken", {31'd0, bp_bus.lk_taken}, 32'd0);
        check("init_lk_target", bp_bus.lk_target, 32'h0000_3004);
        check("init_miss_cnt", bp_bus.miss_cnt, 32'd0);

        // First taken branch allocates
        drive_up(32'h3010, 1'b0, 1'b1, 32'h3040, 1'b0, 32'h3014);
        settle();
        check("alloc_mispredict", {31'd0, bp_bus.mispredict}, 32'd1);
        check("alloc_redirect", bp_bus.redirect_pc, 32'h0000_3040);
        tick();
        idle_up();
        look(32'h0000_3010);
        check("alloc_lk_taken", {31'd0, bp_bus.lk_taken}, 32'd1);
        check("alloc_lk_target", bp_bus.lk_target, 32'h0000_3040);
        check("alloc_miss_cnt", bp_bus.miss_cnt, 32'd1);

        // Counter training: 2 -> 3 (saturate) then down to 0
        for (int i = 0; i < 3; i++) begin
            drive_up(32'h3010, 1'b0, 1'b1, 32'h3040, 1'b1, 32'h3040);
            settle();
            check("train_t_no_mispredict", {31'd0, bp_bus.mispredict}, 32'd0);
            tick();
        end
        drive_up(32'h3010, 1'b0, 1'b0, 32'h3040, 1'b1, 32'h3040);
        settle();
        check("nt1_mispredict", {31'd0, bp_bus.mispredict}, 32'd1);
        check("nt1_redirect", bp_bus.redirect_pc, 32'h0000_3018);
        tick();
        idle_up();
        look(32'h0000_3010);
        check("nt1_still_taken", {31'd0, bp_bus.lk_taken}, 32'd1);
        drive_up(32'h3010, 1'b0, 1'b0, 32'h3040, 1'b1, 32'h3040);
        tick();
        drive_up(32'h3010, 1'b0, 1'b0, 32'h3040, 1'b0, 32'h3014);
        settle();
        check("nt3_no_mispredict", {31'd0, bp_bus.mispredict}, 32'd0);
        tick();
        idle_up();
        look(32'h0000_3010);
        check("nt3_lk_taken", {31'd0, bp_bus.lk_taken}, 32'd0);
        check("nt3_lk_target", bp_bus.lk_target, 32'h0000_3014);
        check("nt3_miss_cnt", bp_bus.miss_cnt, 32'd3);
        // Saturation at zero: one more not-taken, then a single taken stays weak
        drive_up(32'h3010, 1'b0, 1'b0, 32'h3040, 1'b0, 32'h3014);
        tick();
        drive_up(32'h3010, 1'b0, 1'b1, 32'h3040, 1'b0, 32'h3014);
        tick();
        idle_up();
        look(32'h0000_3010);
        check("sat0_lk_taken", {31'd0, bp_bus.lk_taken}, 32'd0);
        check("sat0_miss_cnt", bp_bus.miss_cnt, 32'd4);

        // Register jump with alternating targets
        drive_up(32'h3020, 1'b1, 1'b1, 32'h4000, 1'b0, 32'h3024);
        settle();
        check("jr1_mispredict", {31'd0, bp_bus.mispredict}, 32'd1);
        tick();
        idle_up();
        look(32'h0000_3020);
        check("jr1_lk_taken", {31'd0, bp_bus.lk_taken}, 32'd1);
        check("jr1_lk_target", bp_bus.lk_target, 32'h0000_4000);
        drive_up(32'h3020, 1'b1, 1'b1, 32'h5000, 1'b1, 32'h4000);
        settle();
        check("jr2_mispredict", {31'd0, bp_bus.mispredict}, 32'd1);
        check("jr2_redirect", bp_bus.redirect_pc, 32'h0000_5000);
        tick();
        idle_up();
        look(32'h0000_3020);
        check("jr2_lk_target", bp_bus.lk_target, 32'h0000_5000);
        drive_up(32'h3020, 1'b1, 1'b1, 32'h4000, 1'b1, 32'h5000);
        settle();
        check("jr3_mispredict", {31'd0, bp_bus.mispredict}, 32'd1);
        tick();
        idle_up();
        look(32'h0000_3020);
        check("jr3_lk_taken", {31'd0, bp_bus.lk_taken}, 32'd1);
        check("jr3_lk_target", bp_bus.lk_target, 32'h0000_4000);
        drive_up(32'h3020, 1'b1, 1'b1, 32'h4000, 1'b1, 32'h4000);
        settle();
        check("jr4_no_mispredict", {31'd0, bp_bus.mispredict}, 32'd0);
        tick();
        idle_up();
        check("jr_miss_cnt", bp_bus.miss_cnt, 32'd7);

        // Tag mismatch misses; aliased tag match hits
        look(32'h0000_3120);
        check("tagmiss_lk_taken", {31'd0, bp_bus.lk_taken}, 32'd0);
        check("tagmiss_lk_target", bp_bus.lk_target, 32'h0000_3124);
        look(32'h0001_3020);
        check("alias_lk_taken", {31'd0, bp_bus.lk_taken}, 32'd1);
        check("alias_lk_target", bp_bus.lk_target, 32'h0000_4000);

        // Clearing the jump flag lets the counter decide (3 -> 2 -> 1)
        drive_up(32'h3020, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4000);
        tick();
        drive_up(32'h3020, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4000);
        tick();
        idle_up();
        look(32'h0000_3020);
        check("nojmp_lk_taken", {31'd0, bp_bus.lk_taken}, 32'd0);
        check("nojmp_miss_cnt", bp_bus.miss_cnt, 32'd9);

        // Same-cycle lookup and allocation: read-before-write
        bp_bus.lk_pc = 32'h0000_3030;
        drive_up(32'h3030, 1'b0, 1'b1, 32'h3100, 1'b0, 32'h3034);
        settle();
        check("rbw_lk_taken_now", {31'd0, bp_bus.lk_taken}, 32'd0);
        check("rbw_lk_target_now", bp_bus.lk_target, 32'h0000_3034);
        tick();
        idle_up();
        settle();
        check("rbw_lk_taken_next", {31'd0, bp_bus.lk_taken}, 32'd1);
        check("rbw_lk_target_next", bp_bus.lk_target, 32'h0000_3100);

        // up_valid low: inputs ignored
        drive_up(32'h3060, 1'b0, 1'b1, 32'h3300, 1'b0, 32'h3064);
        bp_bus.up_valid = 1'b0;
        settle();
        check("novalid_mispredict", {31'd0, bp_bus.mispredict}, 32'd0);
        tick();
        idle_up();
        look(32'h0000_3060);
        check("novalid_no_alloc", {31'd0, bp_bus.lk_taken}, 32'd0);
        check("novalid_miss_cnt", bp_bus.miss_cnt, 32'd10);

        // Not-taken miss: no allocation
        drive_up(32'h3070, 1'b0, 1'b0, 32'h3500, 1'b0, 32'h3074);
        tick();
        drive_up(32'h3070, 1'b0, 1'b0, 32'h3500, 1'b1, 32'h3500);
        settle();
        check("ntmiss_mispredict", {31'd0, bp_bus.mispredict}, 32'd1);
        tick();
        idle_up();
        look(32'h0000_3070);
        check("ntmiss_no_alloc", {31'd0, bp_bus.lk_taken}, 32'd0);

        // miss_cnt wrap
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.miss_cnt_q;
        settle();
        check("wrap_preload", bp_bus.miss_cnt, 32'hFFFF_FFFF);
        drive_up(32'h3040, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3080);
        tick();
        idle_up();
        check("wrap_miss_cnt", bp_bus.miss_cnt, 32'd0);

        // Reset mid-stream with a pending allocation
        drive_up(32'h3050, 1'b0, 1'b1, 32'h3200, 1'b0, 32'h3054);
        reset = 1'b0;
        look(32'h0000_3020);
        check("midrst_lk_taken", {31'd0, bp_bus.lk_taken}, 32'd0);
        check("midrst_lk_target", bp_bus.lk_target, 32'h0000_3024);
        look(32'h0000_3030);
        check("midrst_lk_taken2", {31'd0, bp_bus.lk_taken}, 32'd0);
        check("midrst_mispredict", {31'd0, bp_bus.mispredict}, 32'd1);
        tick();
        reset = 1'b1;
        idle_up();
        look(32'h0000_3050);
        check("midrst_discard", {31'd0, bp_bus.lk_taken}, 32'd0);
        check("midrst_miss_cnt", bp_bus.miss_cnt, 32'd0);
        tick();

        // Report
        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
